// File: rtl/unidade_busca.sv
// Instruction fetch stage: owns the PC, fetches over a req/valid handshake,
// latches the word into IR and computes the next PC from the control-unit outputs.
module unidade_busca #(
   parameter int LARG_PC    = 8,
   parameter int LARG_INSTR = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [LARG_PC-1:0]    mem_end,
   output logic                  mem_req,
   input  logic [LARG_INSTR-1:0] mem_dado,
   input  logic                  mem_valido,
   output logic [2:0]            Opcode,
   output logic [2:0]            rs,
   output logic [2:0]            rt,
   output logic [2:0]            rd,
   output logic [6:0]            imm,
   output logic                  instr_valida,
   input  logic                  Beqz,
   input  logic                  Ji,
   input  logic                  EscPC,
   input  logic                  Zero,
   output logic                  parado,
   output logic [LARG_PC-1:0]    pc_atual
);

   typedef enum logic [1:0] {BUSCA, ESPERA, EXEC, HALT} estado_t;

   estado_t               estado, estado_prox;
   logic [LARG_PC-1:0]    pc, pc_prox;
   logic [LARG_INSTR-1:0] ir;
   logic                  carrega_ir;
   logic [LARG_PC-1:0]    desloc;

   // imm7 sign-extended to PC width; the add wraps modulo 2^LARG_PC
   assign desloc = LARG_PC'(signed'(ir[6:0]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado <= BUSCA;
         pc     <= '0;
         ir     <= '0;
      end else begin
         estado <= estado_prox;
         pc     <= pc_prox;
         if (carrega_ir) begin
            ir <= mem_dado;
         end
      end
   end

   always_comb begin
      estado_prox  = estado;
      pc_prox      = pc;
      carrega_ir   = 1'b0;
      mem_req      = 1'b0;
      instr_valida = 1'b0;
      parado       = 1'b0;
      case (estado)
         BUSCA: begin
            // held low while rst is asserted even though the state already reads BUSCA
            mem_req     = !rst;
            estado_prox = ESPERA;
         end
         ESPERA: begin
            if (mem_valido) begin
               carrega_ir  = 1'b1;
               estado_prox = EXEC;
            end
         end
         EXEC: begin
            instr_valida = 1'b1;
            if (!EscPC) begin
               estado_prox = HALT;
            end else begin
               estado_prox = BUSCA;
               if (Ji) begin
                  pc_prox = ir[LARG_PC-1:0];
               end else if (Beqz && Zero) begin
                  pc_prox = pc + LARG_PC'(1) + desloc;
               end else begin
                  pc_prox = pc + LARG_PC'(1);
               end
            end
         end
         HALT: begin
            parado = 1'b1;
         end
         default: begin
            estado_prox = BUSCA;
         end
      endcase
   end

   assign mem_end  = pc;
   assign pc_atual = pc;
   assign Opcode   = ir[15:13];
   assign rs       = ir[12:10];
   assign rt       = ir[9:7];
   assign rd       = ir[6:4];
   assign imm      = ir[6:0];

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: a driver plays a directed instruction table,
// fetch and exec monitors pop expected addresses/words and compare.
module tb_unidade_busca;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  mem_end;
   logic        mem_req;
   logic [15:0] mem_dado = 16'h0000;
   logic        mem_valido = 1'b0;
   logic [2:0]  Opcode, rs, rt, rd;
   logic [6:0]  imm;
   logic        instr_valida;
   logic        Beqz = 1'b0;
   logic        Ji = 1'b0;
   logic        EscPC = 1'b1;
   logic        Zero = 1'b0;
   logic        parado;
   logic [7:0]  pc_atual;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_fetch[$];
   logic [23:0] exp_exec[$];

   typedef struct {
      logic [15:0] dado;
      int          espera;
      logic        beqz;
      logic        ji;
      logic        esc;
      logic        zero;
      logic [7:0]  pc;
      logic [7:0]  prox;
   } txn_t;

   txn_t tab[14];

   unidade_busca #(.LARG_PC(8), .LARG_INSTR(16)) dut (
      .clk(clk), .rst(rst),
      .mem_end(mem_end), .mem_req(mem_req),
      .mem_dado(mem_dado), .mem_valido(mem_valido),
      .Opcode(Opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .instr_valida(instr_valida),
      .Beqz(Beqz), .Ji(Ji), .EscPC(EscPC), .Zero(Zero),
      .parado(parado), .pc_atual(pc_atual)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // fetch monitor: every request must match the next expected address
   initial begin
      logic       prev_req = 1'b0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            check("pulso_req", {31'b0, prev_req}, 32'd0);
            if (exp_fetch.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL req_inesperado: got mem_end=%0h expected no request", mem_end);
            end else begin
               e = exp_fetch.pop_front();
               check("mem_end", {24'b0, mem_end}, {24'b0, e});
               check("pc_fetch", {24'b0, pc_atual}, {24'b0, e});
            end
         end
         prev_req = mem_req;
      end
   end

   // exec monitor: each EXEC cycle must present the expected word at the expected PC
   initial begin
      logic        prev_val = 1'b0;
      logic [23:0] e;
      logic [15:0] d;
      forever begin
         @(negedge clk);
         if (instr_valida) begin
            check("pulso_exec", {31'b0, prev_val}, 32'd0);
            if (exp_exec.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL exec_inesperado: got pc=%0h expected no exec", pc_atual);
            end else begin
               e = exp_exec.pop_front();
               d = e[15:0];
               $display("exec pc=%02h instr=%04h opcode=%0d", pc_atual, d, Opcode);
               check("exec_pc", {24'b0, pc_atual}, {24'b0, e[23:16]});
               check("opcode", {29'b0, Opcode}, {29'b0, d[15:13]});
               check("rs", {29'b0, rs}, {29'b0, d[12:10]});
               check("rt", {29'b0, rt}, {29'b0, d[9:7]});
               check("rd", {29'b0, rd}, {29'b0, d[6:4]});
               check("imm", {25'b0, imm}, {25'b0, d[6:0]});
            end
         end
         prev_val = instr_valida;
      end
   end

   initial begin
      #100000;
      checks++;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      finish_tb();
   end

   task automatic wait_req();
      int n = 0;
      @(negedge clk);
      while (!mem_req) begin
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL wait_req: got no mem_req expected request within 50 cycles");
            finish_tb();
         end
         @(negedge clk);
      end
   endtask

   // entered at a negedge inside ESPERA
   task automatic serve(input txn_t t, input logic [15:0] prev);
      for (int k = 0; k < t.espera; k++) begin
         check("espera_valida", {31'b0, instr_valida}, 32'd0);
         check("espera_end", {24'b0, mem_end}, {24'b0, t.pc});
         check("espera_opcode", {29'b0, Opcode}, {29'b0, prev[15:13]});
         @(negedge clk);
      end
      mem_dado   = t.dado;
      mem_valido = 1'b1;
      @(negedge clk);
      mem_valido = 1'b0;
   endtask

   task automatic run_txn(input txn_t t, input logic [15:0] prev);
      wait_req();
      exp_exec.push_back({t.pc, t.dado});
      if (t.esc) exp_fetch.push_back(t.prox);
      Beqz       = t.beqz;
      Ji         = t.ji;
      EscPC      = t.esc;
      Zero       = t.zero;
      mem_valido = 1'b0;
      @(negedge clk);
      serve(t, prev);
   endtask

   initial begin
      txn_t        fim;
      logic [15:0] prev;
      //          dado    wait beqz ji esc zero  pc     prox
      tab[0]  = '{16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01};
      tab[1]  = '{16'h0000, 4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02};
      tab[2]  = '{16'hA005, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h05};
      tab[3]  = '{16'h607E, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h04};
      tab[4]  = '{16'hA005, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h05};
      tab[5]  = '{16'h607E, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h06};
      tab[6]  = '{16'hA00A, 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06, 8'h0A};
      tab[7]  = '{16'hA020, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h20};
      tab[8]  = '{16'hA0FF, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'hFF};
      tab[9]  = '{16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00};
      tab[10] = '{16'hA0FE, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFE};
      tab[11] = '{16'h6003, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 8'h02};
      tab[12] = '{16'hA007, 3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h07};
      tab[13] = '{16'hE000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h07};

      exp_fetch.push_back(8'h00);
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_valida", {31'b0, instr_valida}, 32'd0);
      check("rst_parado", {31'b0, parado}, 32'd0);
      check("rst_pc", {24'b0, pc_atual}, 32'd0);
      check("rst_opcode", {29'b0, Opcode}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      prev = 16'h0000;
      for (int i = 0; i < 14; i++) begin
         run_txn(tab[i], prev);
         prev = tab[i].dado;
      end

      // halted at PC 7: no further fetches
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("halt_parado", {31'b0, parado}, 32'd1);
         check("halt_pc", {24'b0, pc_atual}, 32'h07);
         check("halt_req", {31'b0, mem_req}, 32'd0);
      end
      check("halt_opcode", {29'b0, Opcode}, 32'd7);

      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst2_pc", {24'b0, pc_atual}, 32'd0);
      check("rst2_parado", {31'b0, parado}, 32'd0);
      check("rst2_req", {31'b0, mem_req}, 32'd0);
      check("rst2_opcode", {29'b0, Opcode}, 32'd0);
      exp_fetch.push_back(8'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset in the middle of ESPERA, valid arriving as reset releases
      wait_req();
      mem_valido = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_fetch.push_back(8'h00);
      @(posedge clk); #1;
      rst        = 1'b0;
      mem_valido = 1'b1;
      mem_dado   = 16'hFFFF;
      @(posedge clk); #1;
      mem_valido = 1'b0;
      @(negedge clk);
      check("rstesp_opcode", {29'b0, Opcode}, 32'd0);
      check("rstesp_imm", {25'b0, imm}, 32'd0);
      check("rstesp_valida", {31'b0, instr_valida}, 32'd0);

      fim = '{16'h2A55, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01};
      exp_exec.push_back({fim.pc, fim.dado});
      exp_fetch.push_back(fim.prox);
      Beqz  = 1'b0;
      Ji    = 1'b0;
      EscPC = 1'b1;
      Zero  = 1'b0;
      serve(fim, 16'h0000);
      wait_req();
      @(negedge clk);

      check("fila_fetch", exp_fetch.size(), 32'd0);
      check("fila_exec", exp_exec.size(), 32'd0);
      finish_tb();
   end

endmodule
